io_sched: RTL

IO_SCHED -- requirements
Module: io_sched

---
 rtl/io_sched_pkg.sv | 23 ++
 rtl/io_rx_fifo.sv | 73 +++++++
 rtl/io_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/io_sched_pkg.sv
// io_sched_pkg: shared types and constants for the io_sched byte scheduler.
//   rx_state_e       : CPU-input assembly FSM states
//   tx_state_e       : UART-sender control FSM states
//   HELLO_BYTE_DEFAULT: byte announced on the sender after every reset
package io_sched_pkg;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_COLLECT = 2'd1,
        R_ACK     = 2'd2
    } rx_state_e;

    typedef enum logic [2:0] {
        T_HELLO = 3'd0,
        T_IDLE  = 3'd1,
        T_START = 3'd2,
        T_BUSY  = 3'd3,
        T_DRAIN = 3'd4
    } tx_state_e;

    localparam logic [7:0] HELLO_BYTE_DEFAULT = 8'hAA;

endpackage

// File: rtl/io_rx_fifo.sv
// io_rx_fifo: circular byte FIFO between the UART receiver and the RX FSM.
//   clk, rstn    : clock, asynchronous active-low reset
//   push_i       : write push_data_i this cycle (dropped when full without a pop)
//   pop_i        : consume the head byte this cycle (ignored when empty)
//   pop_data_o   : head byte, valid while empty_o is low
//   empty_o      : no byte stored
//   count_o      : occupancy, 0..DEPTH
//   overflow_o   : sticky, set when a pushed byte was dropped
module io_rx_fifo
    import io_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    input  logic                     pop_i,
    output logic [7:0]               pop_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic full, empty, pop_ok, push_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop_i & ~empty;
    // A pop in the same cycle frees a slot, so a push on full still lands.
    assign push_ok = push_i & (~full | pop_ok);

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) tail_q <= tail_q + AW'(1);
            if (pop_ok)  head_q <= head_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && !push_ok) overflow_q <= 1'b1;
        end
    end

    // Empty comes from the registered count, so a byte written this cycle
    // is never visible to the reader until the next one.
    assign pop_data_o = mem_q[head_q];
    assign empty_o    = empty;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/io_sched.sv
// io_sched: glue between a UART receiver/sender pair and a CPU request port.
//   clk, rstn          : clock, asynchronous active-low reset
//   rx_data, rx_valid  : receiver byte; one byte captured per rising rx_valid
//   tx_data, tx_start  : byte and one-cycle start pulse to the sender
//   tx_busy            : sender is transmitting
//   in_req, in_word    : CPU read request (held until in_ack), 4-byte or 1-byte
//   in_ack, in_data    : one-cycle completion pulse, assembled value (held)
//   out_req, out_data  : CPU write request (held until out_ack), byte to send
//   out_ack            : one-cycle acceptance pulse
//   rx_count           : receive FIFO occupancy
//   rx_overflow        : sticky, a received byte was dropped
//   rx_state_dbg, tx_state_dbg : current FSM states for observation
// Handshakes: in_req/out_req are levels the CPU holds until the matching
// one-cycle ack; the ack cycle is the only cycle the request is consumed.
module io_sched
    import io_sched_pkg::*;
#(
    parameter int         DEPTH      = 16,
    parameter logic [7:0] HELLO_BYTE = HELLO_BYTE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    input  logic                   in_req,
    input  logic                   in_word,
    output logic                   in_ack,
    output logic [31:0]            in_data,
    input  logic                   out_req,
    input  logic [7:0]             out_data,
    output logic                   out_ack,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   rx_overflow,
    output rx_state_e              rx_state_dbg,
    output tx_state_e              tx_state_dbg
);

    // ---------------- receive capture and FIFO ----------------
    logic       rx_valid_q;
    logic       fifo_push, fifo_pop, fifo_empty;
    logic [7:0] fifo_rdata;

    // Edge detect so a long rx_valid level yields exactly one byte.
    assign fifo_push = rx_valid & ~rx_valid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rx_valid_q <= 1'b0;
        else       rx_valid_q <= rx_valid;
    end

    io_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (fifo_push),
        .push_data_i (rx_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .empty_o     (fifo_empty),
        .count_o     (rx_count),
        .overflow_o  (rx_overflow)
    );

    // ---------------- RX (CPU input) FSM ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic        word_q, word_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] asm_q, asm_d;     // first three bytes of a word, oldest on top
    logic [31:0] in_data_q, in_data_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_q <= R_IDLE;
            word_q     <= 1'b0;
            bcnt_q     <= '0;
            asm_q      <= '0;
            in_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            asm_q      <= asm_d;
            in_data_q  <= in_data_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        word_d     = word_q;
        bcnt_d     = bcnt_q;
        asm_d      = asm_q;
        in_data_d  = in_data_q;
        fifo_pop   = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (in_req) begin
                    word_d     = in_word;
                    bcnt_d     = '0;
                    rx_state_d = R_COLLECT;
                end
            end
            R_COLLECT: begin
                if (!in_req) begin
                    // Abort: partial bytes in asm_q are simply never used.
                    rx_state_d = R_IDLE;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    asm_d    = {asm_q[15:0], fifo_rdata};
                    bcnt_d   = bcnt_q + 2'd1;
                    if (!word_q) begin
                        in_data_d  = {24'h0, fifo_rdata};
                        rx_state_d = R_ACK;
                    end else if (bcnt_q == 2'd3) begin
                        in_data_d  = {asm_q, fifo_rdata};
                        rx_state_d = R_ACK;
                    end
                end
            end
            R_ACK:   rx_state_d = R_IDLE;
            default: rx_state_d = R_IDLE;
        endcase
    end

    assign in_ack       = (rx_state_q == R_ACK);
    assign in_data      = in_data_q;
    assign rx_state_dbg = rx_state_q;

    // ---------------- TX (sender control) FSM ----------------
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_data_q, tx_data_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_q <= T_HELLO;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        out_ack    = 1'b0;
        case (tx_state_q)
            T_HELLO: begin
                if (!tx_busy) begin
                    tx_data_d  = HELLO_BYTE;
                    tx_state_d = T_START;
                end
            end
            T_IDLE: begin
                if (out_req) begin
                    tx_data_d  = out_data;
                    out_ack    = 1'b1;
                    tx_state_d = T_START;
                end
            end
            T_START: tx_state_d = T_BUSY;
            T_BUSY:  if (tx_busy)  tx_state_d = T_DRAIN;
            T_DRAIN: if (!tx_busy) tx_state_d = T_IDLE;
            default: tx_state_d = T_HELLO;
        endcase
    end

    assign tx_start     = (tx_state_q == T_START);
    assign tx_data      = tx_data_q;
    assign tx_state_dbg = tx_state_q;

endmodule
